multicycle_control_unit: RTL and testbench

// Parametrised multicycle successor of the single-cycle RV32I control decoder.
// FSM sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.

---
 rtl/multicycle_control_unit.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB around
// variable-latency memories, traps on illegal opcodes or memory timeouts, counts retirements.
module multicycle_control_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             imemReady,
    input  logic             dmemReady,
    input  logic             trapAck,
    output logic             pcWrite,
    output logic             irWrite,
    output logic             imemReq,
    output logic             dmemReq,
    output logic             regWrite,
    output logic [3:0]       aluOperation,
    output logic [2:0]       immediateSource,
    output logic             aluASrc,
    output logic             aluBSrc,
    output logic             dataMemoryWrite,
    output logic [2:0]       dataMemoryControl,
    output logic [4:0]       branchOperation,
    output logic [1:0]       regDataWriteSource,
    output logic             trap,
    output logic [1:0]       trapCause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_ILL   = 4'd0,
        C_R     = 4'd1,
        C_IALU  = 4'd2,
        C_LD    = 4'd3,
        C_ST    = 4'd4,
        C_BR    = 4'd5,
        C_JAL   = 4'd6,
        C_JALR  = 4'd7,
        C_LUI   = 4'd8,
        C_AUIPC = 4'd9
    } class_t;

    // The wait counter only has to reach MEM_TIMEOUT-1: on that cycle the
    // memory either answers (success) or the FSM leaves for TRAP.
    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] LAST_WAIT = (MEM_TIMEOUT == 0) ? '0 : TW'(MEM_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    class_t           r_class;
    class_t           w_dec_class;
    logic [2:0]       r_funct3;
    logic             r_funct7b5;
    logic [TW-1:0]    r_wait;
    logic [1:0]       r_cause;
    logic [1:0]       w_new_cause;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;
    logic             w_expired;
    logic             w_unused_funct7;

    function automatic class_t classify(input logic [6:0] op);
        class_t c;
        case (op)
            7'b0110011: c = C_R;
            7'b0010011: c = C_IALU;
            7'b0000011: c = C_LD;
            7'b0100011: c = C_ST;
            7'b1100011: c = C_BR;
            7'b1101111: c = C_JAL;
            7'b1100111: c = C_JALR;
            7'b0110111: c = C_LUI;
            7'b0010111: c = C_AUIPC;
            default:    c = C_ILL;
        endcase
        return c;
    endfunction

    assign w_dec_class     = classify(opcode);
    assign w_expired       = (MEM_TIMEOUT != 0) && (r_wait == LAST_WAIT);
    assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign instret         = r_instret;
    assign state           = r_state;

    // Next-state selection and per-phase datapath controls.
    always_comb begin
        w_next             = r_state;
        w_new_cause        = 2'b00;
        w_retire           = 1'b0;
        pcWrite            = 1'b0;
        irWrite            = 1'b0;
        imemReq            = 1'b0;
        dmemReq            = 1'b0;
        regWrite           = 1'b0;
        aluOperation       = 4'b0000;
        immediateSource    = 3'b000;
        aluASrc            = 1'b0;
        aluBSrc            = 1'b0;
        dataMemoryWrite    = 1'b0;
        dataMemoryControl  = 3'b000;
        branchOperation    = 5'b00000;
        regDataWriteSource = 2'b00;
        trap               = 1'b0;
        trapCause          = 2'b00;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                imemReq = 1'b1;
                if (imemReady) begin
                    irWrite = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_expired) begin
                    w_next      = S_TRAP;
                    w_new_cause = 2'b10;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_dec_class == C_ILL) begin
                    w_next      = S_TRAP;
                    w_new_cause = 2'b01;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_WB;
                case (r_class)
                    C_R: begin
                        aluOperation = {r_funct7b5, r_funct3};
                    end
                    C_IALU: begin
                        aluOperation = {r_funct7b5 & (r_funct3 == 3'b101), r_funct3};
                        aluBSrc      = 1'b1;
                    end
                    C_LD: begin
                        aluBSrc = 1'b1;
                        w_next  = S_MEM;
                    end
                    C_ST: begin
                        aluBSrc         = 1'b1;
                        immediateSource = 3'b001;
                        w_next          = S_MEM;
                    end
                    C_BR: begin
                        immediateSource = 3'b101;
                        branchOperation = {2'b01, r_funct3};
                        pcWrite         = 1'b1;
                        w_retire        = 1'b1;
                        w_next          = S_FETCH;
                    end
                    C_JAL: begin
                        aluASrc         = 1'b1;
                        aluBSrc         = 1'b1;
                        immediateSource = 3'b110;
                    end
                    C_JALR: begin
                        aluBSrc = 1'b1;
                    end
                    C_LUI: begin
                        aluOperation    = 4'b1111;
                        aluBSrc         = 1'b1;
                        immediateSource = 3'b010;
                    end
                    C_AUIPC: begin
                        aluASrc         = 1'b1;
                        aluBSrc         = 1'b1;
                        immediateSource = 3'b010;
                    end
                    default: begin
                        w_next      = S_TRAP;
                        w_new_cause = 2'b01;
                    end
                endcase
            end
            S_MEM: begin
                dmemReq           = 1'b1;
                dataMemoryWrite   = (r_class == C_ST);
                dataMemoryControl = r_funct3;
                if (dmemReady) begin
                    if (r_class == C_ST) begin
                        pcWrite  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_expired) begin
                    w_next      = S_TRAP;
                    w_new_cause = 2'b11;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
                case (r_class)
                    C_LD: begin
                        regDataWriteSource = 2'b01;
                    end
                    C_JAL, C_JALR: begin
                        regDataWriteSource = 2'b10;
                        branchOperation    = {2'b10, r_funct3};
                    end
                    default: begin
                        regDataWriteSource = 2'b00;
                    end
                endcase
            end
            S_TRAP: begin
                trap      = 1'b1;
                trapCause = r_cause;
                if (trapAck) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_TRAP;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Decode fields captured while the IR is stable in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_class    <= C_ILL;
            r_funct3   <= 3'b000;
            r_funct7b5 <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_class    <= w_dec_class;
            r_funct3   <= funct3;
            r_funct7b5 <= funct7[5];
        end
    end

    // Memory wait counter, restarted whenever the phase changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
            r_wait <= r_wait + TW'(1);
        end
    end

    // Trap cause: set on entry to TRAP, cleared when the trap is acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cause <= 2'b00;
        end else if ((r_state != S_TRAP) && (w_next == S_TRAP)) begin
            r_cause <= w_new_cause;
        end else if ((r_state == S_TRAP) && (w_next != S_TRAP)) begin
            r_cause <= 2'b00;
        end
    end

    // Retired-instruction counter, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (CNT_W=4, MEM_TIMEOUT=4): phase
// sequencing, decode results, memory handshakes, traps, async reset and counter wrap.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       imemReady = 1'b0;
    logic       dmemReady = 1'b0;
    logic       trapAck = 1'b0;
    logic       pcWrite, irWrite, imemReq, dmemReq, regWrite;
    logic [3:0] aluOperation;
    logic [2:0] immediateSource;
    logic       aluASrc, aluBSrc, dataMemoryWrite;
    logic [2:0] dataMemoryControl;
    logic [4:0] branchOperation;
    logic [1:0] regDataWriteSource;
    logic       trap;
    logic [1:0] trapCause;
    logic [3:0] instret;
    logic [2:0] state;
    logic [27:0] all_out;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [3:0] exp_ir = 4'd0;

    multicycle_control_unit #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .imemReady(imemReady), .dmemReady(dmemReady), .trapAck(trapAck),
        .pcWrite(pcWrite), .irWrite(irWrite), .imemReq(imemReq), .dmemReq(dmemReq),
        .regWrite(regWrite), .aluOperation(aluOperation), .immediateSource(immediateSource),
        .aluASrc(aluASrc), .aluBSrc(aluBSrc), .dataMemoryWrite(dataMemoryWrite),
        .dataMemoryControl(dataMemoryControl), .branchOperation(branchOperation),
        .regDataWriteSource(regDataWriteSource), .trap(trap), .trapCause(trapCause),
        .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    assign all_out = {pcWrite, irWrite, imemReq, dmemReq, regWrite, aluOperation, immediateSource,
                      aluASrc, aluBSrc, dataMemoryWrite, dataMemoryControl, branchOperation,
                      regDataWriteSource, trap, trapCause};

    // Present an instruction in FETCH with ready; returns on the DECODE negedge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op; funct3 = f3; funct7 = f7; imemReady = 1'b1;
        @(negedge clk);
        imemReady = 1'b0;
    endtask

    task automatic retire_addi();
        issue(7'b0010011, 3'b000, 7'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (all_out !== 28'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        n_cmp++; if (instret !== 4'd0) begin n_fail++; $display("FAIL reset_instret: got %0d want 0", instret); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_addi();
        @(negedge clk);
        opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'd0; imemReady = 1'b1;
        #1;
        n_cmp++; if ({state, imemReq, irWrite} !== {3'd1, 2'b11}) begin n_fail++; $display("FAIL addi_fetch: got %b want 00111", {state, imemReq, irWrite}); end
        @(negedge clk); imemReady = 1'b0; #1;
        n_cmp++; if ({state, all_out} !== {3'd2, 28'd0}) begin n_fail++; $display("FAIL addi_decode: got %0d/%h want 2/0", state, all_out); end
        @(negedge clk); #1;
        n_cmp++; if ({state, aluBSrc, aluOperation, regWrite, pcWrite} !== {3'd3, 1'b1, 4'b0000, 2'b00}) begin n_fail++; $display("FAIL addi_exec: got %b want 011100000", {state, aluBSrc, aluOperation, regWrite, pcWrite}); end
        @(negedge clk); #1;
        n_cmp++; if ({state, regWrite, pcWrite, regDataWriteSource} !== {3'd5, 2'b11, 2'b00}) begin n_fail++; $display("FAIL addi_wb: got %b want 1011100", {state, regWrite, pcWrite, regDataWriteSource}); end
        exp_ir++;
        @(negedge clk); #1;
        n_cmp++; if ({state, regWrite, instret} !== {3'd1, 1'b0, exp_ir}) begin n_fail++; $display("FAIL addi_retire: got st=%0d rw=%0d ir=%0d want 1/0/%0d", state, regWrite, instret, exp_ir); end
    endtask

    task automatic test_lw();
        issue(7'b0000011, 3'b010, 7'd0);
        @(negedge clk); #1;
        n_cmp++; if ({state, aluBSrc, immediateSource} !== {3'd3, 1'b1, 3'b000}) begin n_fail++; $display("FAIL lw_exec: got %b want 0111000", {state, aluBSrc, immediateSource}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); dmemReady = (i == 3); #1;
            n_cmp++; if ({state, dmemReq, dataMemoryWrite, dataMemoryControl, pcWrite} !== {3'd4, 2'b10, 3'b010, 1'b0}) begin n_fail++; $display("FAIL lw_mem%0d: got %b want 100100100", i, {state, dmemReq, dataMemoryWrite, dataMemoryControl, pcWrite}); end
        end
        @(negedge clk); dmemReady = 1'b0; #1;
        n_cmp++; if ({state, regWrite, regDataWriteSource, dmemReq} !== {3'd5, 1'b1, 2'b01, 1'b0}) begin n_fail++; $display("FAIL lw_wb: got %b want 1011010", {state, regWrite, regDataWriteSource, dmemReq}); end
        exp_ir++;
        @(negedge clk); #1;
        n_cmp++; if ({state, instret} !== {3'd1, exp_ir}) begin n_fail++; $display("FAIL lw_retire: got st=%0d ir=%0d want 1/%0d", state, instret, exp_ir); end
    endtask

    task automatic test_alu_ops();
        logic [6:0] ops [6] = '{7'b0110011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0110111, 7'b0010111};
        logic [2:0] f3s [6] = '{3'b000, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000};
        logic [6:0] f7s [6] = '{7'b0100000, 7'b0100000, 7'b0000000, 7'b0100000, 7'b0000000, 7'b0000000};
        logic [8:0] exp [6] = '{{4'b1000, 3'b000, 2'b00}, {4'b1101, 3'b000, 2'b01}, {4'b0101, 3'b000, 2'b01},
                                {4'b0000, 3'b000, 2'b01}, {4'b1111, 3'b010, 2'b01}, {4'b0000, 3'b010, 2'b11}};
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], f3s[i], f7s[i]);
            @(negedge clk); #1;
            n_cmp++; if ({aluOperation, immediateSource, aluASrc, aluBSrc} !== exp[i]) begin n_fail++; $display("FAIL alu_exec%0d: got %b want %b", i, {aluOperation, immediateSource, aluASrc, aluBSrc}, exp[i]); end
            @(negedge clk); #1;
            n_cmp++; if ({state, regWrite, pcWrite, regDataWriteSource, aluOperation} !== {3'd5, 2'b11, 2'b00, 4'b0000}) begin n_fail++; $display("FAIL alu_wb%0d: got %b", i, {state, regWrite, pcWrite, regDataWriteSource, aluOperation}); end
            exp_ir++;
            @(negedge clk);
        end
        #1;
        n_cmp++; if (instret !== exp_ir) begin n_fail++; $display("FAIL alu_instret: got %0d want %0d", instret, exp_ir); end
    endtask

    task automatic test_branch();
        logic [2:0] f3s [2] = '{3'b000, 3'b111};
        for (int i = 0; i < 2; i++) begin
            issue(7'b1100011, f3s[i], 7'd0);
            @(negedge clk); #1;
            n_cmp++; if ({state, branchOperation, pcWrite, regWrite, immediateSource} !== {3'd3, 2'b01, f3s[i], 2'b10, 3'b101}) begin n_fail++; $display("FAIL br_exec%0d: got %b", i, {state, branchOperation, pcWrite, regWrite, immediateSource}); end
            exp_ir++;
            @(negedge clk); #1;
            n_cmp++; if ({state, regWrite, instret} !== {3'd1, 1'b0, exp_ir}) begin n_fail++; $display("FAIL br_retire%0d: got st=%0d rw=%0d ir=%0d want 1/0/%0d", i, state, regWrite, instret, exp_ir); end
        end
    endtask

    task automatic test_jump();
        issue(7'b1101111, 3'b000, 7'd0);
        @(negedge clk); #1;
        n_cmp++; if ({aluASrc, aluBSrc, immediateSource, branchOperation} !== {2'b11, 3'b110, 5'b00000}) begin n_fail++; $display("FAIL jal_exec: got %b", {aluASrc, aluBSrc, immediateSource, branchOperation}); end
        @(negedge clk); #1;
        n_cmp++; if ({regDataWriteSource, branchOperation, regWrite, pcWrite} !== {2'b10, 5'b10000, 2'b11}) begin n_fail++; $display("FAIL jal_wb: got %b want 101000011", {regDataWriteSource, branchOperation, regWrite, pcWrite}); end
        exp_ir++;
        @(negedge clk);
        issue(7'b1100111, 3'b000, 7'd0);
        @(negedge clk); #1;
        n_cmp++; if ({aluASrc, aluBSrc, immediateSource} !== {2'b01, 3'b000}) begin n_fail++; $display("FAIL jalr_exec: got %b want 01000", {aluASrc, aluBSrc, immediateSource}); end
        @(negedge clk); #1;
        n_cmp++; if ({regDataWriteSource, branchOperation} !== {2'b10, 5'b10000}) begin n_fail++; $display("FAIL jalr_wb: got %b want 1010000", {regDataWriteSource, branchOperation}); end
        exp_ir++;
        @(negedge clk);
    endtask

    task automatic test_store();
        issue(7'b0100011, 3'b010, 7'd0);
        @(negedge clk); #1;
        n_cmp++; if ({aluBSrc, immediateSource, dmemReq} !== {1'b1, 3'b001, 1'b0}) begin n_fail++; $display("FAIL sw_exec: got %b want 10010", {aluBSrc, immediateSource, dmemReq}); end
        @(negedge clk); dmemReady = 1'b1; #1;
        n_cmp++; if ({state, dmemReq, dataMemoryWrite, dataMemoryControl, pcWrite, regWrite} !== {3'd4, 2'b11, 3'b010, 2'b10}) begin n_fail++; $display("FAIL sw_mem: got %b want 1001101010", {state, dmemReq, dataMemoryWrite, dataMemoryControl, pcWrite, regWrite}); end
        exp_ir++;
        @(negedge clk); dmemReady = 1'b0; #1;
        n_cmp++; if ({state, instret} !== {3'd1, exp_ir}) begin n_fail++; $display("FAIL sw_retire: got st=%0d ir=%0d want 1/%0d", state, instret, exp_ir); end
    endtask

    task automatic test_illegal();
        issue(7'b1111111, 3'b000, 7'd0);
        @(negedge clk); #1;
        n_cmp++; if ({state, all_out} !== {3'd6, 28'd5}) begin n_fail++; $display("FAIL ill_trap: got %0d/%h want 6/5", state, all_out); end
        n_cmp++; if (instret !== exp_ir) begin n_fail++; $display("FAIL ill_instret: got %0d want %0d", instret, exp_ir); end
        @(negedge clk); trapAck = 1'b1; #1;
        n_cmp++; if ({state, trap, trapCause} !== {3'd6, 3'b101}) begin n_fail++; $display("FAIL ill_hold: got %b want 110101", {state, trap, trapCause}); end
        @(negedge clk); trapAck = 1'b0; #1;
        n_cmp++; if ({state, trap, trapCause, imemReq} !== {3'd1, 3'b000, 1'b1}) begin n_fail++; $display("FAIL ill_ack: got %b want 0010001", {state, trap, trapCause, imemReq}); end
    endtask

    task automatic test_imem_timeout();
        for (int i = 0; i < 4; i++) begin
            if (i != 0) begin @(negedge clk); #1; end
            n_cmp++; if ({state, imemReq, irWrite} !== {3'd1, 2'b10}) begin n_fail++; $display("FAIL imem_wait%0d: got %b want 00110", i, {state, imemReq, irWrite}); end
        end
        @(negedge clk); #1;
        n_cmp++; if ({state, all_out} !== {3'd6, 28'd6}) begin n_fail++; $display("FAIL imem_trap: got %0d/%h want 6/6", state, all_out); end
        trapAck = 1'b1;
        @(negedge clk); trapAck = 1'b0; #1;
        n_cmp++; if ({state, trapCause} !== {3'd1, 2'b00}) begin n_fail++; $display("FAIL imem_ack: got %b want 00100", {state, trapCause}); end
    endtask

    task automatic test_dmem_timeout();
        issue(7'b0000011, 3'b000, 7'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_cmp++; if ({state, dmemReq} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL dmem_wait%0d: got %b want 1001", i, {state, dmemReq}); end
        end
        @(negedge clk); #1;
        n_cmp++; if ({state, all_out} !== {3'd6, 28'd7}) begin n_fail++; $display("FAIL dmem_trap: got %0d/%h want 6/7", state, all_out); end
        n_cmp++; if (instret !== exp_ir) begin n_fail++; $display("FAIL dmem_instret: got %0d want %0d", instret, exp_ir); end
        trapAck = 1'b1;
        @(negedge clk); trapAck = 1'b0; #1;
        n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL dmem_ack: got %0d want 1", state); end
    endtask

    task automatic test_reset_mid_mem();
        issue(7'b0000011, 3'b010, 7'd0);
        @(negedge clk);
        @(negedge clk); #1;
        n_cmp++; if ({state, dmemReq} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL rst_pre: got %b want 1001", {state, dmemReq}); end
        #2 rst_n = 1'b0;
        #1;
        exp_ir = 4'd0;
        n_cmp++; if ({state, all_out, instret} !== {3'd0, 28'd0, 4'd0}) begin n_fail++; $display("FAIL rst_async: got st=%0d out=%h ir=%0d want 0/0/0", state, all_out, instret); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if ({state, imemReq} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL rst_restart: got %b want 0011", {state, imemReq}); end
    endtask

    task automatic test_back_to_back_wrap();
        for (int i = 1; i <= 17; i++) begin
            retire_addi();
            exp_ir++;
            #1;
            if (i >= 15) begin
                n_cmp++; if (instret !== exp_ir) begin n_fail++; $display("FAIL wrap_%0d: got %0d want %0d", i, instret, exp_ir); end
            end
        end
        n_cmp++; if (instret !== 4'd1) begin n_fail++; $display("FAIL wrap_final: got %0d want 1", instret); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_lw();
        test_alu_ops();
        test_branch();
        test_jump();
        test_store();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_reset_mid_mem();
        test_back_to_back_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
